mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_ctrl_pkg.sv | 15 +
 rtl/mult_arbiter_if.sv | 31 +++
 rtl/rr_arbiter2.sv | 30 +++
 rtl/mult_arbiter.sv | 85 ++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the two-requester multiplier arbiter: requester count,
// default operand width and pipeline latency, and the requester-id type.
package mult_ctrl_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DEF_N   = 32;
  localparam int unsigned DEF_LAT = 2;

  typedef logic [0:0] req_id_t;

  function automatic req_id_t other_id(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester, response and multiplier-side signals of mult_arbiter.
// The slave modport is the arbiter; master is the surrounding requesters/multiplier.
interface mult_arbiter_if #(
  parameter int unsigned N = mult_ctrl_pkg::DEF_N
);
  import mult_ctrl_pkg::*;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*N-1:0] req_b;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [NUM_REQ-1:0]   rsp_ready;
  logic [2*N-1:0]       rsp_result;
  logic                 mult_en;
  logic [N-1:0]         mult_a;
  logic [N-1:0]         mult_b;
  logic [2*N-1:0]       mult_result;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mult_result,
    output req_ready, rsp_valid, rsp_result, mult_en, mult_a, mult_b, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mult_result,
    input  req_ready, rsp_valid, rsp_result, mult_en, mult_a, mult_b, busy
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. A lone requester wins outright; on contention the
// pointer decides, and after every accept the pointer moves to the loser.
module rr_arbiter2 import mult_ctrl_pkg::*; (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            gnt_id,
  output logic               accept
);

  req_id_t ptr_q;
  req_id_t ptr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    gnt_id = ptr_q;
    if (req == 2'b01)      gnt_id = 1'b0;
    else if (req == 2'b10) gnt_id = 1'b1;
    accept = en & (|req);
    grant  = accept ? (NUM_REQ'(1) << gnt_id) : '0;
    ptr_d  = accept ? other_id(gnt_id) : ptr_q;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one external pipelined multiplier between two requesters, tracking
// which requester owns each in-flight product and stalling on a held result.
module mult_arbiter import mult_ctrl_pkg::*; #(
  parameter int unsigned N   = DEF_N,
  parameter int unsigned LAT = DEF_LAT
) (
  input  logic           clk,
  input  logic           reset,
  mult_arbiter_if.slave  bus
);

  logic [LAT-1:0]          vld_q, vld_d;
  req_id_t [LAT-1:0]       tag_q, tag_d;
  logic [N-1:0]            opa_q, opa_d;
  logic [N-1:0]            opb_q, opb_d;
  logic                    mult_en;
  logic                    arb_en;
  logic                    accept;
  logic [NUM_REQ-1:0]      grant;
  req_id_t                 gnt_id;
  logic                    out_vld;
  req_id_t                 out_tag;

  assign out_vld = vld_q[LAT-1];
  assign out_tag = tag_q[LAT-1];
  assign mult_en = ~(out_vld & ~bus.rsp_ready[out_tag]);
  // Keep the requesters shut out for as long as reset is held low.
  assign arb_en  = mult_en & reset;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (arb_en),
    .req    (bus.req_valid),
    .grant  (grant),
    .gnt_id (gnt_id),
    .accept (accept)
  );

  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    if (accept) begin
      opa_d = (gnt_id == 1'b1) ? bus.req_a[N +: N] : bus.req_a[0 +: N];
      opb_d = (gnt_id == 1'b1) ? bus.req_b[N +: N] : bus.req_b[0 +: N];
    end
  end

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (mult_en) begin
      for (int i = LAT - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
      vld_d[0] = accept;
      if (accept) tag_d[0] = gnt_id;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      tag_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

  // Operands are presented combinationally on a grant and held otherwise.
  assign bus.mult_a     = opa_d;
  assign bus.mult_b     = opb_d;
  assign bus.mult_en    = mult_en;
  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = {out_vld & (out_tag == 1'b1), out_vld & (out_tag == 1'b0)};
  assign bus.rsp_result = bus.mult_result;
  assign bus.busy       = |vld_q;

endmodule
